// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode definitions and the arbiter's response-buffer state encoding.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_NEG  = 4'd2,
    OP_ADDU = 4'd3,
    OP_SUBU = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_ASL  = 4'd9,
    OP_ASR  = 4'd10,
    OP_LSL  = 4'd11,
    OP_LSR  = 4'd12
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: signed/unsigned add-subtract, logic ops and shifts with zero/overflow/negative flags.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              negative
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;
  logic [SH_W-1:0] sh_s;

  // Opcode decode; unsigned overflow is carry-out for ADDU and borrow for SUBU
  always_comb begin
    sum_s    = {1'b0, a} + {1'b0, b};
    diff_s   = {1'b0, a} - {1'b0, b};
    sh_s     = b[SH_W-1:0];
    result   = {DATA_W{1'b0}};
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum_s[DATA_W-1:0];
        overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result   = diff_s[DATA_W-1:0];
        overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_NEG: begin
        result   = {DATA_W{1'b0}} - a;
        overflow = a[MSB] && result[MSB];
      end
      OP_ADDU: begin
        result   = sum_s[DATA_W-1:0];
        overflow = sum_s[DATA_W];
      end
      OP_SUBU: begin
        result   = diff_s[DATA_W-1:0];
        overflow = diff_s[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_ASL:  result = a <<< sh_s;
      OP_ASR:  result = $signed(a) >>> sh_s;
      OP_LSL:  result = a << sh_s;
      OP_LSR:  result = a >> sh_s;
      default: result = {DATA_W{1'b0}};
    endcase
  end

  assign zero     = (result == {DATA_W{1'b0}});
  assign negative = result[MSB];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, with a single-entry result register.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_negative
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic              last_gnt_r;
  logic              gnt_s;
  logic              can_accept_s;
  logic              accept_s;
  logic [OP_W-1:0]   alu_op_s;
  logic [DATA_W-1:0] alu_a_s;
  logic [DATA_W-1:0] alu_b_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_zero_s;
  logic              alu_ovf_s;
  logic              alu_neg_s;

  // Grant selection, handshake and operand mux; ready never looks at op or operands
  always_comb begin
    can_accept_s = (state_r == ST_EMPTY) || ((state_r == ST_FULL) && rsp_ready);
    if (req0_valid && req1_valid) begin
      gnt_s = ~last_gnt_r;
    end else if (req1_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    req0_ready = rst_n && can_accept_s && (gnt_s == 1'b0);
    req1_ready = rst_n && can_accept_s && (gnt_s == 1'b1);
    accept_s   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    if (gnt_s) begin
      alu_op_s = req1_op;
      alu_a_s  = req1_a;
      alu_b_s  = req1_b;
    end else begin
      alu_op_s = req0_op;
      alu_a_s  = req0_a;
      alu_b_s  = req0_b;
    end
  end

  alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .op       (alu_op_s),
    .a        (alu_a_s),
    .b        (alu_b_s),
    .result   (alu_res_s),
    .zero     (alu_zero_s),
    .overflow (alu_ovf_s),
    .negative (alu_neg_s)
  );

  // Result buffer occupancy: a simultaneous drain and accept keeps it full
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) state_nxt_s = ST_FULL;
        else          state_nxt_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (rsp_ready && !accept_s) state_nxt_s = ST_EMPTY;
        else                        state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result capture and round-robin pointer, both advanced only on an accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_r   <= 1'b1;
      rsp_id       <= 1'b0;
      rsp_out      <= {DATA_W{1'b0}};
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_negative <= 1'b0;
    end else if (accept_s) begin
      last_gnt_r   <= gnt_s;
      rsp_id       <= gnt_s;
      rsp_out      <= alu_res_s;
      rsp_zero     <= alu_zero_s;
      rsp_overflow <= alu_ovf_s;
      rsp_negative <= alu_neg_s;
    end
  end

  assign rsp_valid = (state_r == ST_FULL);

endmodule
